// File: rtl/enc_pkg.sv
// Helpers shared by the encoder family: index width and population count.
package enc_pkg;

  localparam int ENC_MAX_N = 1024;

  function automatic int idx_w(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < n) w = i + 1;
    return w;
  endfunction

  function automatic int unsigned popcount(input logic [ENC_MAX_N-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < ENC_MAX_N; i++)
      c += {31'd0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/prio_find.sv
// Combinational lowest-set-bit finder.
module prio_find #(
  parameter int N = 8,
  parameter int W = enc_pkg::idx_w(N)
) (
  input  logic [N-1:0] req,
  output logic         found,
  output logic [W-1:0] idx
);

  // Scan high to low so the lowest set bit is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = W'(i);
      end
    end
  end

endmodule

// File: rtl/rr_prio_encoder.sv
// N-input priority encoder, fixed or round-robin per beat, with a registered
// valid/ready output stage carrying index, multi-hot flag and popcount.
module rr_prio_encoder
  import enc_pkg::*;
#(
  parameter int N = 8,
  parameter int W = idx_w(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_req,
  input  logic         in_rr_en,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_multi,
  output logic [W:0]   out_count
);

  logic [W-1:0] r_ptr;
  logic [N-1:0] w_mask;
  logic         w_found_m, w_found_a;
  logic [W-1:0] w_idx_m, w_idx_a, w_idx, w_ptr_nxt;
  logic [W:0]   w_count;
  logic         w_accept, w_load;

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_mask
      assign w_mask[g] = (W'(g) >= r_ptr);
    end
  endgenerate

  prio_find #(.N(N), .W(W)) u_find_masked (
    .req   (in_req & w_mask),
    .found (w_found_m),
    .idx   (w_idx_m)
  );

  prio_find #(.N(N), .W(W)) u_find_all (
    .req   (in_req),
    .found (w_found_a),
    .idx   (w_idx_a)
  );

  // Nothing at or above the pointer: wrap to the lowest set bit overall.
  assign w_idx     = (in_rr_en && w_found_m) ? w_idx_m : w_idx_a;
  assign w_ptr_nxt = (w_idx == W'(N - 1)) ? '0 : w_idx + W'(1);
  assign w_count   = (W + 1)'(popcount(ENC_MAX_N'(in_req)));

  assign in_ready  = !out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  // A zero vector is consumed without producing a beat.
  assign w_load    = w_accept && w_found_a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr     <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_multi <= 1'b0;
      out_count <= '0;
    end else begin
      if (w_load) begin
        out_valid <= 1'b1;
        out_idx   <= w_idx;
        out_multi <= (w_count > (W + 1)'(1));
        out_count <= w_count;
        if (in_rr_en) r_ptr <= w_ptr_nxt;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
